// File: rtl/rom_loader_pkg.sv
// Shared constants, FSM encodings and address helper for the boot ROM loader.
package rom_loader_pkg;

    localparam int         INST_ADDR_W = 32;
    localparam int         INST_W      = 32;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CNT0, ST_CNT1, ST_DATA, ST_WRITE, ST_CHK, ST_DONE, ST_ERR
    } ld_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_e;

    function automatic logic [INST_ADDR_W-1:0] word_addr(input logic [15:0] idx);
        return INST_ADDR_W'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/rom_loader_if.sv
// ROM write port plus core reset and load status, driven by the loader.
interface rom_loader_if;
    logic                                ld_we;
    logic [rom_loader_pkg::INST_ADDR_W-1:0] ld_addr;
    logic [rom_loader_pkg::INST_W-1:0]   ld_wdata;
    logic                                core_rst;
    logic                                ld_done;
    logic                                ld_err;

    modport master (output ld_we, ld_addr, ld_wdata, core_rst, ld_done, ld_err);
    modport slave  (input  ld_we, ld_addr, ld_wdata, core_rst, ld_done, ld_err);
endinterface

// File: rtl/rom_loader_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, start confirmed at DIV/2, one-cycle valid at stop mid-point.
// No backpressure; a byte is presented once and lost if ignored.
module rom_loader_uart_rx import rom_loader_pkg::*; #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       rx_ferr_o
);
    localparam int              CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0]   HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL = CW'(DIV - 1);

    rx_state_e     st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d, data_q, data_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;
    logic          s1_q, s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= RX_IDLE; cnt_q <= '0; bit_q <= '0; sh_q <= '0; data_q <= '0;
            valid_q <= 1'b0; ferr_q <= 1'b0; s1_q <= 1'b1; s2_q <= 1'b1;
        end else begin
            st_q <= st_d; cnt_q <= cnt_d; bit_q <= bit_d; sh_q <= sh_d; data_q <= data_d;
            valid_q <= valid_d; ferr_q <= ferr_d; s1_q <= rxd_i; s2_q <= s1_q;
        end
    end

    always_comb begin
        st_d = st_q; cnt_d = cnt_q; bit_d = bit_q; sh_d = sh_q;
        data_d = data_q; ferr_d = ferr_q; valid_d = 1'b0;
        case (st_q)
            RX_IDLE: if (!s2_q) begin st_d = RX_START; cnt_d = '0; end
            RX_START: if (cnt_q == HALF) begin
                cnt_d = '0; bit_d = '0;
                st_d  = s2_q ? RX_IDLE : RX_DATA;
            end else cnt_d = cnt_q + 1'b1;
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {s2_q, sh_q[7:1]};
                if (bit_q == 3'd7) st_d = RX_STOP;
                else               bit_d = bit_q + 3'd1;
            end else cnt_d = cnt_q + 1'b1;
            RX_STOP: if (cnt_q == FULL) begin
                cnt_d = '0; valid_d = 1'b1; data_d = sh_q; ferr_d = !s2_q;
                // a low stop bit must not be mistaken for the next start edge
                st_d  = s2_q ? RX_IDLE : RX_BREAK;
            end else cnt_d = cnt_q + 1'b1;
            RX_BREAK: if (s2_q) st_d = RX_IDLE;
            default:  st_d = RX_IDLE;
        endcase
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = data_q;
    assign rx_ferr_o  = ferr_q;
endmodule

// File: rtl/rom_loader.sv
// Framed UART program loader into the instruction ROM; holds the core in reset while loading.
// ld_we rises 1 cycle after a word's last byte, core_rst 2 cycles after a good checksum; no backpressure.
module rom_loader import rom_loader_pkg::*; #(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         BAUD      = 115200,
    parameter int         MAX_WORDS = 4096,
    parameter logic [7:0] SYNC      = SYNC_BYTE,
    parameter int         TIMEOUT   = 16 * (CLK_FREQ / BAUD) * 10,
    parameter int         BOOT_HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         uart_rxd,
    rom_loader_if.master ld
);
    localparam logic [16:0] MAX_N    = 17'(MAX_WORDS);
    localparam logic [31:0] IDLE_LIM = 32'(TIMEOUT - 1);

    logic       rx_valid, rx_ferr, rx_ok, in_frame;
    logic [7:0] rx_data;
    logic [15:0] n_cnt;

    ld_state_e               state_q, state_d;
    logic [15:0]             cnt_q, cnt_d, word_idx_q, word_idx_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [31:0]             buf_q, buf_d, idle_q, idle_d;
    logic [7:0]              chk_q, chk_d;
    logic                    we_q, we_d, done_q, done_d, err_q, err_d, core_rst_q, core_rst_d;
    logic [INST_ADDR_W-1:0]  addr_q, addr_d;
    logic [INST_W-1:0]       wdata_q, wdata_d;

    rom_loader_uart_rx #(.DIV(CLK_FREQ / BAUD)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd_i      (uart_rxd),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .rx_ferr_o  (rx_ferr)
    );

    assign rx_ok    = rx_valid && !rx_ferr;
    assign in_frame = state_q inside {ST_CNT0, ST_CNT1, ST_DATA, ST_WRITE, ST_CHK};
    assign n_cnt    = {rx_data, cnt_q[7:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE; cnt_q <= '0; word_idx_q <= '0; byte_idx_q <= '0;
            buf_q <= '0; chk_q <= '0; idle_q <= '0;
            we_q <= 1'b0; addr_q <= '0; wdata_q <= '0; done_q <= 1'b0; err_q <= 1'b0;
            core_rst_q <= (BOOT_HOLD == 0);
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; word_idx_q <= word_idx_d; byte_idx_q <= byte_idx_d;
            buf_q <= buf_d; chk_q <= chk_d; idle_q <= idle_d;
            we_q <= we_d; addr_q <= addr_d; wdata_q <= wdata_d; done_q <= done_d; err_q <= err_d;
            core_rst_q <= core_rst_d;
        end
    end

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; word_idx_d = word_idx_q; byte_idx_d = byte_idx_q;
        buf_d = buf_q; chk_d = chk_q; idle_d = '0;
        we_d = 1'b0; addr_d = addr_q; wdata_d = wdata_q;
        done_d = done_q; err_d = err_q; core_rst_d = core_rst_q;
        if (in_frame) idle_d = rx_valid ? '0 : idle_q + 32'd1;
        unique case (state_q)
            ST_IDLE: if (rx_ok && rx_data == SYNC) begin
                state_d = ST_CNT0; done_d = 1'b0; err_d = 1'b0; core_rst_d = 1'b0;
                word_idx_d = '0; byte_idx_d = '0; chk_d = '0;
            end
            ST_CNT0: if (rx_ok) begin cnt_d[7:0] = rx_data; state_d = ST_CNT1; end
            ST_CNT1: if (rx_ok) begin
                cnt_d   = n_cnt;
                state_d = (n_cnt == 16'd0 || {1'b0, n_cnt} > MAX_N) ? ST_ERR : ST_DATA;
            end
            ST_DATA: if (rx_ok) begin
                buf_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                chk_d      = chk_q + rx_data;
                byte_idx_d = byte_idx_q + 2'd1;
                // launch the write from the fourth byte directly so ld_we trails it by one cycle
                if (byte_idx_q == 2'd3) begin
                    we_d    = 1'b1;
                    addr_d  = word_addr(word_idx_q);
                    wdata_d = {rx_data, buf_q[23:0]};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_q + 16'd1 == cnt_q) ? ST_CHK : ST_DATA;
            end
            ST_CHK: if (rx_ok) state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
            ST_DONE: begin done_d = 1'b1; core_rst_d = 1'b1; state_d = ST_IDLE; end
            ST_ERR:  begin err_d = 1'b1; state_d = ST_IDLE; end
        endcase
        if (in_frame && rx_valid && rx_ferr)               state_d = ST_ERR;
        else if (in_frame && !rx_valid && idle_q >= IDLE_LIM) state_d = ST_ERR;
    end

    assign ld.ld_we    = we_q;
    assign ld.ld_addr  = addr_q;
    assign ld.ld_wdata = wdata_q;
    assign ld.core_rst = core_rst_q;
    assign ld.ld_done  = done_q;
    assign ld.ld_err   = err_q;
endmodule

// File: tb/tb_rom_loader.sv
// Randomized frame bench for rom_loader with a write scoreboard and queued status probes.
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int CLK_FREQ = 8;
    localparam int BAUD     = 1;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int MAX_W    = 8;
    localparam int TOUT     = 16 * DIV * 10;

    localparam int K_RESET = 0, K_FLAGS = 1, K_PEND = 2, K_LAT = 3, K_ADDR = 4;

    typedef struct { int kind; logic [71:0] val; } probe_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;

    logic [63:0] exp_q[$];
    probe_t      st_q[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_we = 0;
    int   rise_cyc = 0;
    logic prev_crst = 1'b0;

    always #5 clk = ~clk;

    rom_loader_if ld0();
    rom_loader_if ld1();

    rom_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_WORDS(MAX_W), .BOOT_HOLD(1)) dut (
        .clk(clk), .rst(rst), .uart_rxd(rxd), .ld(ld0));
    rom_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_WORDS(MAX_W), .BOOT_HOLD(0)) dut_nh (
        .clk(clk), .rst(rst), .uart_rxd(rxd), .ld(ld1));

    // Monitor: scores every ROM write and every queued status probe.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [71:0] act;
        probe_t      p;
        string       nm;
        cyc = cyc + 1;
        if (rst && ld0.ld_we) begin
            last_we = cyc;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write: got addr %h data %h, required no write", ld0.ld_addr, ld0.ld_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({ld0.ld_addr, ld0.ld_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write: got addr %h data %h, required addr %h data %h",
                             ld0.ld_addr, ld0.ld_wdata, e[63:32], e[31:0]);
                end
            end
        end
        if (ld0.core_rst && !prev_crst) rise_cyc = cyc;
        prev_crst = ld0.core_rst;
        if (st_q.size() > 0) begin
            p = st_q.pop_front();
            case (p.kind)
                K_RESET: begin nm = "reset_state";
                    act = {3'b0, ld0.ld_we, ld0.ld_addr, ld0.ld_wdata,
                           ld0.ld_done, ld0.ld_err, ld0.core_rst, ld1.core_rst}; end
                K_FLAGS: begin nm = "done_err_crst_crstnh";
                    act = {68'b0, ld0.ld_done, ld0.ld_err, ld0.core_rst, ld1.core_rst}; end
                K_PEND:  begin nm = "pending_writes"; act = 72'(exp_q.size()); end
                K_LAT:   begin nm = "core_rst_latency"; act = 72'(rise_cyc - last_we); end
                default: begin nm = "last_addr"; act = {40'b0, ld0.ld_addr}; end
            endcase
            n_vec++;
            if (act !== p.val) begin
                n_err++;
                $display("FAIL %s: got %h, required %h", nm, act, p.val);
            end
        end
    end

    function automatic void probe(input int kind, input logic [71:0] val);
        probe_t p;
        p.kind = kind;
        p.val  = val;
        st_q.push_back(p);
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        rxd = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(DIV);
        end
        rxd = stop;
        wait_cyc(DIV);
        rxd = 1'b1;
    endtask

    // Reference: a frame with 1..MAX_W words writes every word at index*4 and is good
    // only when the trailing byte equals the byte-sum of the data.
    task automatic send_frame(input int n, input logic [31:0] w[$], input logic [7:0] delta,
                              input bit probe_sync);
        logic [7:0]  sum;
        logic [15:0] n16;
        logic [31:0] wd;
        bit          n_ok, good;
        sum  = 8'd0;
        n16  = 16'(n);
        n_ok = (n >= 1 && n <= MAX_W);
        good = n_ok && (delta == 8'd0);
        send_byte(SYNC_BYTE, 1'b1);
        if (probe_sync) begin
            probe(K_FLAGS, 72'b0000);
            wait_cyc(2);
        end
        send_byte(n16[7:0], 1'b1);
        send_byte(n16[15:8], 1'b1);
        if (n_ok) begin
            for (int i = 0; i < n; i++) begin
                wd = w[i];
                exp_q.push_back({32'(i * 4), wd});
                for (int b = 0; b < 4; b++) sum = sum + wd[8*b +: 8];
            end
            for (int i = 0; i < n; i++) begin
                wd = w[i];
                for (int b = 0; b < 4; b++) send_byte(wd[8*b +: 8], 1'b1);
            end
            send_byte(sum + delta, 1'b1);
        end
        wait_cyc(2 * DIV);
        probe(K_FLAGS, {68'b0, good, !good, good, good});
        probe(K_PEND, 72'd0);
        if (good) probe(K_LAT, 72'(10 * DIV + 1));
        wait_cyc(4);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] wa, wb;
        logic [7:0]  d;
        rst = 1'b0;
        rxd = 1'b1;
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(3);
        probe(K_RESET, 72'b0001);
        wait_cyc(2);

        // known program; its data byte-sum is 0x0B
        w = '{32'h00500293, 32'h00100313};
        send_frame(2, w, 8'd0, 1'b1);
        send_frame(2, w, 8'd1, 1'b0);

        // SYNC bytes inside data are plain data
        w = '{32'hA5A5A5A5, 32'h000000A5, 32'h12345678};
        send_frame(3, w, 8'd0, 1'b0);

        w = {};
        send_frame(0, w, 8'd0, 1'b0);
        send_frame(MAX_W + 1, w, 8'd0, 1'b0);
        for (int i = 0; i < MAX_W; i++) w.push_back($urandom);
        send_frame(MAX_W, w, 8'd0, 1'b0);
        probe(K_ADDR, 72'((MAX_W - 1) * 4));
        wait_cyc(2);

        // inter-byte timeout after the first count byte
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'd2, 1'b1);
        wait_cyc(TOUT - 20);
        probe(K_FLAGS, 72'b0000);
        wait_cyc(30);
        probe(K_FLAGS, 72'b0100);
        wait_cyc(2);
        w = '{$urandom};
        send_frame(1, w, 8'd0, 1'b0);

        // framing error on the second data byte
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'd2, 1'b1);
        send_byte(8'd0, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        wait_cyc(4 * DIV);
        probe(K_FLAGS, 72'b0100);
        probe(K_PEND, 72'd0);
        wait_cyc(3);

        // a broken SYNC while idle must be ignored
        send_byte(SYNC_BYTE, 1'b0);
        wait_cyc(4 * DIV);
        probe(K_FLAGS, 72'b0100);
        wait_cyc(2);

        for (int k = 0; k < 5; k++) begin
            int n;
            n = $urandom_range(1, MAX_W);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            send_frame(n, w, d, 1'b0);
        end

        // reset in the middle of word 1
        wa = $urandom;
        wb = $urandom;
        exp_q.push_back({32'd0, wa});
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'd2, 1'b1);
        send_byte(8'd0, 1'b1);
        for (int b = 0; b < 4; b++) send_byte(wa[8*b +: 8], 1'b1);
        send_byte(wb[7:0], 1'b1);
        rxd = 1'b0;
        wait_cyc(3 * DIV);
        #3 rst = 1'b0;
        rxd = 1'b1;
        probe(K_RESET, 72'b0001);
        wait_cyc(3);
        rst = 1'b1;
        probe(K_RESET, 72'b0001);
        probe(K_PEND, 72'd0);
        wait_cyc(4 * DIV);
        w = '{$urandom, $urandom};
        send_frame(2, w, 8'd0, 1'b0);

        wait_cyc(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
